// File: rtl/uart_cmd_decoder.sv
`timescale 1ns/1ps
// uart_cmd_decoder
// Frames the UART byte stream as SYNC, ADDR, D[0..N-1], CSUM packets. A frame
// whose XOR checksum matches becomes a single-cycle register write. A bad
// checksum, or too long a gap between bytes inside a frame, drops the frame
// and raises a one-cycle error pulse. The decoder then waits for the next sync
// byte. Sync bytes seen inside a frame are treated as ordinary data.
module uart_cmd_decoder #(
    parameter int          DATA_BYTES   = 2,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CLKS = 100000
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    wr_en,
    output logic [7:0]              wr_addr,
    output logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    frame_err,
    output logic                    timeout_err,
    output logic                    busy
);

    localparam int DW    = 8 * DATA_BYTES;
    localparam int CTR_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int BCW   = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    localparam logic [CTR_W-1:0] IDLE_LIMIT = CTR_W'(TIMEOUT_CLKS - 1);
    localparam logic [BCW-1:0]   LAST_BYTE  = BCW'(DATA_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CTR_W-1:0]   idle_ctr_q;
    logic [BCW-1:0]     byte_ctr_q;
    logic [7:0]         csum_acc_q;
    logic [7:0]         shadow_addr_q;
    logic [DW-1:0]      shadow_data_q;

    logic               wr_en_q, frame_err_q, timeout_err_q;
    logic [7:0]         wr_addr_q;
    logic [DW-1:0]      wr_data_q;

    logic               timeout_hit;
    logic               wr_en_d, frame_err_d, timeout_err_d;

    // A received byte always beats the timeout threshold on the same edge.
    assign timeout_hit = (state_q != ST_IDLE) && !rx_valid && (idle_ctr_q == IDLE_LIMIT);

    // State register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: advance one field per received byte, fall back to IDLE on a timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (rx_valid && (rx_data == SYNC_BYTE)) state_d = ST_ADDR;
            ST_ADDR: if (rx_valid) state_d = ST_DATA;
            ST_DATA: if (rx_valid && (byte_ctr_q == LAST_BYTE)) state_d = ST_CSUM;
            ST_CSUM: if (rx_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (timeout_hit) begin
            state_d = ST_IDLE;
        end
    end

    // Output decode: event pulses to register next edge, and busy straight from state.
    always_comb begin
        wr_en_d       = (state_q == ST_CSUM) && rx_valid && (rx_data == csum_acc_q);
        frame_err_d   = (state_q == ST_CSUM) && rx_valid && (rx_data != csum_acc_q);
        timeout_err_d = timeout_hit;
        busy          = (state_q != ST_IDLE);
    end

    // Frame datapath: gap counter, byte counter, running checksum and shadow registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            idle_ctr_q    <= '0;
            byte_ctr_q    <= '0;
            csum_acc_q    <= '0;
            shadow_addr_q <= '0;
            shadow_data_q <= '0;
        end else begin
            if (rx_valid || (state_q == ST_IDLE)) begin
                idle_ctr_q <= '0;
            end else begin
                idle_ctr_q <= idle_ctr_q + CTR_W'(1);
            end

            if (timeout_hit) begin
                byte_ctr_q    <= '0;
                csum_acc_q    <= '0;
                shadow_addr_q <= '0;
                shadow_data_q <= '0;
            end else if (rx_valid) begin
                unique case (state_q)
                    ST_ADDR: begin
                        shadow_addr_q <= rx_data;
                        csum_acc_q    <= rx_data;
                        byte_ctr_q    <= '0;
                    end
                    ST_DATA: begin
                        shadow_data_q <= DW'({shadow_data_q, rx_data});
                        csum_acc_q    <= csum_acc_q ^ rx_data;
                        if (byte_ctr_q == LAST_BYTE) begin
                            byte_ctr_q <= '0;
                        end else begin
                            byte_ctr_q <= byte_ctr_q + BCW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Registered write port and error pulses; address and data hold between writes.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_en_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            wr_en_q       <= wr_en_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
            if (wr_en_d) begin
                wr_addr_q <= shadow_addr_q;
                wr_data_q <= shadow_data_q;
            end
        end
    end

    assign wr_en       = wr_en_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
`timescale 1ns/1ps
// Testbench for uart_cmd_decoder: directed frames feed a queue of expected
// events, and a monitor compares every event the DUT raises against it.
module tb_uart_cmd_decoder;

    localparam int TOUT = 50;

    localparam logic [2:0] EV_WR = 3'b001;
    localparam logic [2:0] EV_FE = 3'b010;
    localparam logic [2:0] EV_TO = 3'b100;

    logic        clk;
    logic        n_reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;
    logic        timeout_err;
    logic        busy;

    typedef struct {
        logic [2:0]  kind;
        logic [7:0]  addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        expQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          lastByteCyc = 0;
    logic [7:0]  heldAddr = 8'h00;
    logic [15:0] heldData = 16'h0000;

    uart_cmd_decoder #(
        .DATA_BYTES  (2),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CLKS(TOUT)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_err  (frame_err),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle the DUT raises an event, pop and compare one expectation.
    always @(negedge clk) begin
        logic [2:0] ev;
        exp_t       e;
        ev = {timeout_err, frame_err, wr_en};
        if (n_reset === 1'b1 && ev !== 3'b000) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_event: got events=%b, expected none (cycle %0d)", ev, cyc);
            end else begin
                e = expQ.pop_front();
                checkOutput("event_kind", ev, e.kind);
                checkOutput("event_cycle", cyc, e.cyc);
                checkOutput("wr_addr", wr_addr, e.addr);
                checkOutput("wr_data", wr_data, e.data);
                checkOutput("busy_at_event", busy, 0);
            end
        end
    end

    task automatic putByte(input logic [7:0] b);
        @(negedge clk);
        rx_valid    = 1'b1;
        rx_data     = b;
        lastByteCyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic expectEvent(input logic [2:0] kind, input int atCyc);
        exp_t e;
        e.kind = kind;
        e.addr = heldAddr;
        e.data = heldData;
        e.cyc  = atCyc;
        expQ.push_back(e);
    endtask

    // Send a frame on consecutive cycles; goodCsum says whether the hand-computed csum is right.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] cs, input bit goodCsum);
        putByte(8'hA5);
        putByte(a);
        putByte(d0);
        putByte(d1);
        putByte(cs);
        if (goodCsum) begin
            heldAddr = a;
            heldData = {d0, d1};
            expectEvent(EV_WR, lastByteCyc);
        end else begin
            expectEvent(EV_FE, lastByteCyc);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wr_en"}, wr_en, 0);
        checkOutput({tag, "_wr_addr"}, wr_addr, 0);
        checkOutput({tag, "_wr_data"}, wr_data, 0);
        checkOutput({tag, "_frame_err"}, frame_err, 0);
        checkOutput({tag, "_timeout_err"}, timeout_err, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int t0;
        int waited;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        n_reset  = 1'b0;
        #1;
        checkAllZero("reset");
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        idle(2);

        // Basic good frame, busy high after the sync byte
        putByte(8'hA5);
        idle(1);
        checkOutput("busy_after_sync", busy, 1);
        putByte(8'h12);
        putByte(8'h34);
        putByte(8'h56);
        putByte(8'h70);
        heldAddr = 8'h12;
        heldData = 16'h3456;
        expectEvent(EV_WR, lastByteCyc);
        idle(3);
        checkOutput("busy_after_write", busy, 0);

        // Bad checksum keeps previous address/data
        applyStimulus(8'h12, 8'h34, 8'h56, 8'h71, 1'b0);
        idle(3);

        // Leading junk bytes are ignored
        putByte(8'h00);
        putByte(8'hFF);
        putByte(8'h12);
        idle(1);
        checkOutput("busy_after_junk", busy, 0);
        applyStimulus(8'h12, 8'h34, 8'h56, 8'h70, 1'b1);
        idle(3);

        // Timeout after the address byte, then a clean frame
        putByte(8'hA5);
        putByte(8'h12);
        t0 = lastByteCyc;
        expectEvent(EV_TO, t0 + TOUT);
        idle(TOUT + 10);
        applyStimulus(8'h01, 8'hAB, 8'hCD, 8'h67, 1'b1);
        idle(3);

        // Byte arriving on the threshold edge beats the timeout
        putByte(8'hA5);
        putByte(8'h12);
        idle(TOUT - 1);
        putByte(8'h34);
        putByte(8'h56);
        putByte(8'h70);
        heldAddr = 8'h12;
        heldData = 16'h3456;
        expectEvent(EV_WR, lastByteCyc);
        idle(3);

        // Two frames back to back; second sync lands in the wr_en cycle
        applyStimulus(8'h12, 8'h34, 8'h56, 8'h70, 1'b1);
        applyStimulus(8'h01, 8'hAB, 8'hCD, 8'h67, 1'b1);
        idle(3);

        // Reset mid-frame abandons it with no stale write
        putByte(8'hA5);
        putByte(8'h12);
        putByte(8'h34);
        @(negedge clk);
        rx_valid = 1'b0;
        n_reset  = 1'b0;
        #1;
        checkAllZero("midreset");
        heldAddr = 8'h00;
        heldData = 16'h0000;
        repeat (3) @(negedge clk);
        checkAllZero("midreset_hold");
        n_reset = 1'b1;
        idle(2);
        applyStimulus(8'h20, 8'h00, 8'h01, 8'h21, 1'b1);
        idle(3);

        // Drain the scoreboard with a bounded wait
        waited = 0;
        while (expQ.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        idle(TOUT + 10);
        checkOutput("queue_drained", expQ.size(), 0);
        checkOutput("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Byte-stream command controller that sits directly behind the test-harness UART receiver and turns received bytes into register-write transactions. It frames a fixed-format packet (sync, address, data, checksum), checks integrity, and issues a single-cycle write strobe to the harness register bank. Malformed or stalled frames are dropped, flagged, and the decoder resynchronises on the next sync byte.

## Interface
- DATA_BYTES, 2: payload bytes per frame; wr_data width = 8*DATA_BYTES; legal range ≥1.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CLKS, 100000: max clocks between consecutive bytes inside a frame; legal range ≥2.

- clk  in  1  system clock; all logic on rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle pulse per received byte.
- rx_data  in  8  received byte; qualified by rx_valid.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  8  write address; held between strobes.
- wr_data  out  8*DATA_BYTES  write data, first payload byte in MSBs; held between strobes.
- frame_err  out  1  one-cycle pulse: checksum mismatch.
- timeout_err  out  1  one-cycle pulse: inter-byte timeout inside a frame.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Frame: SYNC_BYTE, ADDR, D[0]..D[DATA_BYTES-1], CSUM; CSUM = ADDR ^ D[0] ^ … ^ D[DATA_BYTES-1].
- States: IDLE, ADDR, DATA, CSUM. Transitions on rx_valid only (plus timeout).
- IDLE: rx_valid && rx_data==SYNC_BYTE → ADDR; any other byte discarded, no error.
- ADDR: rx_valid → latch address into shadow reg, csum_acc = rx_data, byte_ctr = 0, → DATA.
- DATA: rx_valid → shift byte into shadow data (left shift, new byte in LSBs), csum_acc ^= rx_data; byte_ctr == DATA_BYTES-1 → CSUM, else byte_ctr+1.
- CSUM: rx_valid → if rx_data==csum_acc: load wr_addr/wr_data from shadow, pulse wr_en; else pulse frame_err; → IDLE in both cases.
- SYNC_BYTE received in ADDR/DATA/CSUM is ordinary frame content; no mid-frame resync.
- Timeout counter idle_ctr, width $clog2(TIMEOUT_CLKS): cleared on any edge with rx_valid=1 or in IDLE; otherwise increments. Edge with state≠IDLE, rx_valid=0, idle_ctr==TIMEOUT_CLKS-1 → state IDLE, timeout_err pulse, shadow contents discarded.
- Simultaneous rx_valid and timeout threshold: byte wins; processed normally, counter cleared, no timeout_err.
- wr_en, frame_err, timeout_err mutually exclusive, each high exactly one cycle per event.

## Timing
- Reset (async assert, sync-released use): state IDLE; wr_en 0, wr_addr 0, wr_data 0, frame_err 0, timeout_err 0, busy 0; idle_ctr, byte_ctr, csum_acc, shadow regs 0.
- Reset asserted mid-frame: frame abandoned, no strobe or error pulse.
- Latency: wr_en / frame_err registered, high the cycle after the CSUM byte's rx_valid; wr_addr/wr_data valid in that same cycle and held until next wr_en.
- timeout_err high the cycle after the TIMEOUT_CLKS-th edge following the last in-frame rx_valid.
- busy registered from state: rises cycle after sync byte, falls same cycle wr_en/frame_err/timeout_err rises.
- Back-to-back: sync byte may arrive in the cycle wr_en is high; accepted (state already IDLE).
- rx_valid assumed non-consecutive is NOT required; consecutive-cycle bytes must be handled.

## Test plan
- DATA_BYTES=2: bytes A5 12 34 56 70 → one wr_en pulse, wr_addr=0x12, wr_data=0x3456, no errors, busy low after.
- Same frame with CSUM 0x71 → frame_err one cycle, no wr_en, wr_addr/wr_data keep previous values.
- Bytes 00 FF 12 then A5 12 34 56 70 → leading bytes ignored, single write 0x12/0x3456.
- TIMEOUT_CLKS=50: A5 12 then silence → timeout_err exactly 50 edges after 0x12 byte; then A5 01 AB CD 67 → write 0x01/0xABCD.
- TIMEOUT_CLKS=50: next byte's rx_valid on the threshold edge → no timeout_err, frame completes; two complete frames on consecutive-cycle rx_valid → two wr_en pulses.
- n_reset low after A5 12 34, release, send A5 20 00 01 21 → no stale write, single write 0x20/0x0001, all outputs 0 during reset.
